row_token_scanner: RTL and testbench

Token-issuing side of the row readout chain. Latches per-row hit-pending flags and grants a one-hot token to the highest-priority pending row (row 0 highest). Presents the granted row's token and its binary row address to the downstream readout over a valid/ready handshake. On each accept, clears the served row and advances to the next pending row. Sits between the pixel-row hit flags and the column readout logic that consumes the 4-bit row address.

---
 rtl/row_token_scanner.sv | 132 +++++++++++++
 tb/tb_row_token_scanner.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/row_token_scanner.sv
// Row token scanner: latches per-row hit flags and presents the lowest-indexed pending row
//   as a one-hot token plus binary address.
// Latency: a hit sampled at edge N gives valid after edge N+2. There is one bubble cycle
//   between back-to-back rows.
// Backpressure: the presented row is held stable while ready=0. Pending hits keep merging
//   into the pending flags.
//
// Ports:
//   clk, rst_n     rising-edge clock; synchronous active-low reset
//   hit_in         per-row hit set pulses (bit k = row k), ignored while freeze=1
//   freeze         masks hit_in; rows that are already pending still drain
//   token_out      one-hot token of the presented row (all-zero only after reset)
//   row_addr       binary index of the presented row
//   valid/ready    presentation handshake; a row is accepted when both are 1
//   busy           a row is pending or the scanner is not idle
//   served_cnt     saturating count of accepted rows
//   row_addr_par   XOR of row_addr, present only when ROW_TOKEN_PARITY_EN is defined
module row_token_scanner #(
    parameter int NROWS = 16,
    parameter int AW    = 4,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NROWS-1:0] hit_in,
    input  logic             freeze,
    output logic [NROWS-1:0] token_out,
    output logic [AW-1:0]    row_addr,
    output logic             valid,
    input  logic             ready,
    output logic             busy,
    output logic [CNTW-1:0]  served_cnt
`ifdef ROW_TOKEN_PARITY_EN
    ,
    output logic             row_addr_par
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [NROWS-1:0] pending, pending_next;
    logic [NROWS-1:0] clr;
    logic [NROWS-1:0] grant;
    logic [AW-1:0]    grant_addr;
    logic             accept;
    logic             load_en;

    // Priority encoder. The loop scans downward so that the lowest set index
    // is the one that remains at the end.
    always_comb begin
        grant      = '0;
        grant_addr = '0;
        for (int i = NROWS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                grant      = '0;
                grant[i]   = 1'b1;
                grant_addr = AW'(i);
            end
        end
    end

    // valid is a registered state bit, so it only rises in PRESENT.
    assign valid  = (state == PRESENT);
    assign accept = valid & ready;
    assign clr    = accept ? token_out : '0;

    // A set and a clear on the same row in the same cycle leave the row pending.
    // The set term is ORed in after the clear is applied.
    assign pending_next = (pending & ~clr) | (freeze ? '0 : hit_in);

    assign busy = (|pending) | (state != IDLE);

    always_comb begin
        state_next = state;
        load_en    = 1'b0;
        case (state)
            IDLE: begin
                if (|pending) state_next = LOAD;
            end
            LOAD: begin
                load_en    = 1'b1;
                state_next = PRESENT;
            end
            PRESENT: begin
                if (accept) state_next = (|(pending & ~clr)) ? LOAD : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending    <= '0;
            token_out  <= '0;
            row_addr   <= '0;
            served_cnt <= '0;
        end else begin
            pending <= pending_next;
            if (load_en) begin
                token_out <= grant;
                row_addr  <= grant_addr;
            end
            if (accept && (served_cnt != {CNTW{1'b1}})) begin
                served_cnt <= served_cnt + 1'b1;
            end
        end
    end

`ifdef ROW_TOKEN_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_addr_par <= 1'b0;
        end else if (load_en) begin
            row_addr_par <= ^grant_addr;
        end
    end
`endif

endmodule

// File: tb/tb_row_token_scanner.sv
module tb_row_token_scanner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] hit_in = '0;
    logic        freeze = 1'b0;
    logic [15:0] token_out;
    logic [3:0]  row_addr;
    logic        valid;
    logic        ready = 1'b0;
    logic        busy;
    logic [7:0]  served_cnt;
`ifdef ROW_TOKEN_PARITY_EN
    logic        row_addr_par;
`endif

    int vectors = 0;
    int miscompares = 0;

    row_token_scanner #(.NROWS(16), .AW(4), .CNTW(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hit_in     (hit_in),
        .freeze     (freeze),
        .token_out  (token_out),
        .row_addr   (row_addr),
        .valid      (valid),
        .ready      (ready),
        .busy       (busy),
        .served_cnt (served_cnt)
`ifdef ROW_TOKEN_PARITY_EN
        ,
        .row_addr_par (row_addr_par)
`endif
    );

    always #5 clk = ~clk;

    // Reference model. It tracks the set of pending rows, whether a row is on
    // offer, and whether the next edge is the single bubble that picks the next row.
    logic [15:0] m_pend;
    logic        m_valid;
    logic        m_bubble;
    int          m_row;
    int          m_cnt;

    function automatic int lowest_row(input logic [15:0] v);
        for (int k = 0; k < 16; k++) if (v[k]) return k;
        return -1;
    endfunction

    task automatic model_edge();
        logic [15:0] served;
        logic [15:0] next_pend;
        if (!rst_n) begin
            m_pend = '0; m_valid = 0; m_bubble = 0; m_row = -1; m_cnt = 0;
            return;
        end
        served = '0;
        if (m_valid && ready) served[m_row] = 1'b1;
        next_pend = (m_pend & ~served) | (freeze ? 16'h0 : hit_in);
        if (m_bubble) begin
            m_row = lowest_row(m_pend);
            m_valid = 1;
            m_bubble = 0;
        end else if (m_valid) begin
            if (ready) begin
                if (m_cnt < 255) m_cnt++;
                m_valid = 0;
                m_bubble = ((m_pend & ~served) != 0);
            end
        end else begin
            m_bubble = (m_pend != 0);
        end
        m_pend = next_pend;
    endtask

    // Inputs change at the falling edge. The model advances at the rising edge,
    // and outputs are observed at the following falling edge.
    task automatic step(input logic [15:0] h, input logic f, input logic r);
        hit_in = h; freeze = f; ready = r;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(16'hFFFF, 1'b0, 1'b1);
        step(16'h0000, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({valid, busy, token_out, row_addr, served_cnt} !== 30'd0) begin
            miscompares++;
            $display("FAIL reset_state got v=%0b b=%0b tok=%h addr=%0d cnt=%0d want all zero",
                     valid, busy, token_out, row_addr, served_cnt);
        end
    endtask

    task automatic test_single_hit();
        do_reset();
        step(16'h0020, 1'b0, 1'b1);
        step(16'h0000, 1'b0, 1'b1);
        vectors++;
        if (valid !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_early got v=%0b b=%0b want v=0 b=1", valid, busy);
        end
        step(16'h0000, 1'b0, 1'b1);
        vectors++;
        if (valid !== 1'b1 || row_addr !== 4'd5 || token_out !== 16'h0020) begin
            miscompares++;
            $display("FAIL single_present got v=%0b addr=%0d tok=%h want 1/5/0020", valid, row_addr, token_out);
        end
        step(16'h0000, 1'b0, 1'b1);
        vectors++;
        if (valid !== 1'b0 || served_cnt !== 8'd1 || busy !== 1'b0 || token_out !== 16'h0020) begin
            miscompares++;
            $display("FAIL single_accept got v=%0b cnt=%0d b=%0b tok=%h want 0/1/0/0020",
                     valid, served_cnt, busy, token_out);
        end
    endtask

    task automatic test_priority_drain();
        int rows[$];
        int times[$];
        int exp_rows[4] = '{0, 5, 10, 15};
        do_reset();
        step(16'h8421, 1'b0, 1'b1);
        for (int c = 0; c < 14; c++) begin
            if (valid === 1'b1) begin rows.push_back(int'(row_addr)); times.push_back(c); end
            step(16'h0000, 1'b0, 1'b1);
        end
        vectors++;
        if (rows.size() != 4) begin
            miscompares++;
            $display("FAIL drain_count got %0d rows want 4", rows.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (rows[i] != exp_rows[i]) begin
                    miscompares++;
                    $display("FAIL drain_order[%0d] got %0d want %0d", i, rows[i], exp_rows[i]);
                end
                if (i > 0) begin
                    vectors++;
                    if (times[i] - times[i-1] != 2) begin
                        miscompares++;
                        $display("FAIL drain_gap[%0d] got %0d want 2", i, times[i] - times[i-1]);
                    end
                end
            end
        end
        vectors++;
        if (served_cnt !== 8'd4) begin
            miscompares++;
            $display("FAIL drain_cnt got %0d want 4", served_cnt);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        step(16'h0003, 1'b0, 1'b0);
        step(16'h0000, 1'b0, 1'b0);
        step(16'h0000, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            vectors++;
            if (valid !== 1'b1 || row_addr !== 4'd0 || token_out !== 16'h0001) begin
                miscompares++;
                $display("FAIL bp_hold[%0d] got v=%0b addr=%0d tok=%h want 1/0/0001", c, valid, row_addr, token_out);
            end
            step(16'h0000, 1'b0, 1'b0);
        end
        step(16'h0000, 1'b0, 1'b1);
        vectors++;
        if (valid !== 1'b0 || served_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL bp_accept got v=%0b cnt=%0d want 0/1", valid, served_cnt);
        end
        step(16'h0000, 1'b0, 1'b0);
        step(16'h0000, 1'b0, 1'b0);
        vectors++;
        if (valid !== 1'b1 || row_addr !== 4'd1 || token_out !== 16'h0002) begin
            miscompares++;
            $display("FAIL bp_next got v=%0b addr=%0d tok=%h want 1/1/0002", valid, row_addr, token_out);
        end
    endtask

    task automatic test_collision();
        do_reset();
        step(16'h0008, 1'b0, 1'b0);
        step(16'h0000, 1'b0, 1'b0);
        step(16'h0000, 1'b0, 1'b0);
        step(16'h0008, 1'b0, 1'b1);
        vectors++;
        if (valid !== 1'b0 || served_cnt !== 8'd1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL coll_accept got v=%0b cnt=%0d b=%0b want 0/1/1", valid, served_cnt, busy);
        end
        step(16'h0000, 1'b0, 1'b0);
        step(16'h0000, 1'b0, 1'b0);
        vectors++;
        if (valid !== 1'b1 || row_addr !== 4'd3) begin
            miscompares++;
            $display("FAIL coll_reserve got v=%0b addr=%0d want 1/3", valid, row_addr);
        end
        step(16'h0000, 1'b0, 1'b1);
        vectors++;
        if (served_cnt !== 8'd2 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL coll_cnt got cnt=%0d b=%0b want 2/0", served_cnt, busy);
        end
    endtask

    task automatic test_freeze();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            step(16'hFFFF, 1'b1, 1'b1);
            vectors++;
            if (valid !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL freeze[%0d] got v=%0b b=%0b want 0/0", c, valid, busy);
            end
        end
    endtask

    task automatic test_saturation();
        int accepts = 0;
        do_reset();
        for (int c = 0; c < 900 && accepts < 300; c++) begin
            if (valid === 1'b1) accepts++;
            step(16'hFFFF, 1'b0, 1'b1);
        end
        vectors++;
        if (accepts != 300 || served_cnt !== 8'd255) begin
            miscompares++;
            $display("FAIL saturate got accepts=%0d cnt=%0d want 300/255", accepts, served_cnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(16'h00C0, 1'b0, 1'b0);
        step(16'h0000, 1'b0, 1'b0);
        step(16'h0000, 1'b0, 1'b0);
        step(16'h0000, 1'b0, 1'b1);
        step(16'h0000, 1'b0, 1'b0);
        step(16'h0000, 1'b0, 1'b0);
        vectors++;
        if (valid !== 1'b1 || row_addr !== 4'd7 || served_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL mid_pre got v=%0b addr=%0d cnt=%0d want 1/7/1", valid, row_addr, served_cnt);
        end
        rst_n = 1'b0;
        step(16'h0000, 1'b0, 1'b0);
        rst_n = 1'b1;
        vectors++;
        if (valid !== 1'b0 || token_out !== 16'h0 || served_cnt !== 8'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset got v=%0b tok=%h cnt=%0d b=%0b want 0/0000/0/0",
                     valid, token_out, served_cnt, busy);
        end
        step(16'h0000, 1'b0, 1'b1);
        step(16'h0000, 1'b0, 1'b1);
        vectors++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_dropped got v=%0b b=%0b want 0/0", valid, busy);
        end
    endtask

    task automatic test_random();
        logic [15:0] h;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            h = ($urandom_range(0, 3) == 0) ? (16'($urandom) & 16'($urandom) & 16'($urandom)) : 16'h0;
            rst_n = ($urandom_range(0, 299) != 0);
            step(h, ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) != 0));
            rst_n = 1'b1;
            vectors++;
            if (valid !== m_valid || busy !== ((m_pend != 0) || m_valid || m_bubble) ||
                served_cnt !== 8'(m_cnt)) begin
                miscompares++;
                $display("FAIL rand_ctl[%0d] got v=%0b b=%0b cnt=%0d want v=%0b b=%0b cnt=%0d", c,
                         valid, busy, served_cnt, m_valid, (m_pend != 0) || m_valid || m_bubble, m_cnt);
            end
            vectors++;
            if (m_row >= 0 && (row_addr !== 4'(m_row) || token_out !== (16'h1 << m_row))) begin
                miscompares++;
                $display("FAIL rand_row[%0d] got addr=%0d tok=%h want addr=%0d", c, row_addr, token_out, m_row);
            end else if (m_row < 0 && token_out !== 16'h0) begin
                miscompares++;
                $display("FAIL rand_tok0[%0d] got tok=%h want 0000", c, token_out);
            end
`ifdef ROW_TOKEN_PARITY_EN
            vectors++;
            if (row_addr_par !== ((m_row >= 0) ? ^(4'(m_row)) : 1'b0)) begin
                miscompares++;
                $display("FAIL rand_par[%0d] got %0b for row %0d", c, row_addr_par, m_row);
            end
`endif
        end
    endtask

    initial begin
        m_pend = '0; m_valid = 0; m_bubble = 0; m_row = -1; m_cnt = 0;
        @(negedge clk);
        test_reset();
        test_single_hit();
        test_priority_drain();
        test_backpressure();
        test_collision();
        test_freeze();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
